// File: rtl/xmode_counter_pkg.sv
// xmode_counter_pkg: stepping modes, bounce direction and default width for xmode_counter.
package xmode_counter_pkg;
  localparam int XC_WIDTH = 12;
  typedef enum logic [1:0] {
    XM_UP     = 2'b00,
    XM_DOWN   = 2'b01,
    XM_BOUNCE = 2'b10,
    XM_STEP2  = 2'b11
  } xmode_t;
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;
endpackage

// File: rtl/xmode_counter.sv
// xmode_counter: 12-bit modulo counter with up-wrap, down-reload, bounce and double-step modes,
// all bounded by a runtime terminal value.
module xmode_counter
  import xmode_counter_pkg::*;
#(
  parameter int WIDTH = XC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_enb,
  input  logic [1:0]       Xmode,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] r_out, w_nxt;
  dir_t             r_dir, w_dir_nxt;
  logic [WIDTH:0]   w_inc, w_inc2, w_lim;
  assign w_lim  = {1'b0, LoadVal};
  assign w_inc  = {1'b0, r_out} + (WIDTH+1)'(1);
  assign w_inc2 = {1'b0, r_out} + (WIDTH+1)'(2);
  always_comb begin
    w_nxt     = r_out;
    w_dir_nxt = r_dir;
    case (xmode_t'(Xmode))
      XM_DOWN: w_nxt = (r_out == '0 || r_out > LoadVal) ? LoadVal : r_out - WIDTH'(1);
      XM_BOUNCE: begin
        if (LoadVal == '0) begin
          w_nxt = '0;
        end else if (r_out > LoadVal) begin
          w_nxt     = LoadVal;
          w_dir_nxt = DIR_DOWN;
        end else if (r_dir == DIR_UP) begin
          // turning at the top emits LoadVal-1 so each endpoint appears once per sweep
          w_nxt     = (r_out == LoadVal) ? LoadVal - WIDTH'(1) : w_inc[WIDTH-1:0];
          w_dir_nxt = (r_out == LoadVal) ? DIR_DOWN : DIR_UP;
        end else begin
          w_nxt     = (r_out == '0) ? WIDTH'(1) : r_out - WIDTH'(1);
          w_dir_nxt = (r_out == '0) ? DIR_UP : DIR_DOWN;
        end
      end
      XM_STEP2: w_nxt = (w_inc2 > w_lim) ? '0 : w_inc2[WIDTH-1:0];
      default:  w_nxt = (w_inc > w_lim) ? '0 : w_inc[WIDTH-1:0];
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_dir <= DIR_UP;
    end else if (cnt_enb) begin
      r_out <= w_nxt;
      r_dir <= w_dir_nxt;
    end
  end
  assign out = r_out;
endmodule

// File: tb/tb_xmode_counter.sv
// tb_xmode_counter: directed vectors with hand-computed counts for every stepping mode.
module tb_xmode_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_enb = 1'b0;
  logic [1:0]  Xmode = 2'b00;
  logic [11:0] LoadVal = 12'd0;
  logic [11:0] out;
  int n_checks = 0;
  int n_errors = 0;

  xmode_counter dut (
    .clk(clk), .rst_n(rst_n), .cnt_enb(cnt_enb),
    .Xmode(Xmode), .LoadVal(LoadVal), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_to(input logic [11:0] lim, input int n);
    pulse_reset();
    Xmode   = 2'b00;
    LoadVal = lim;
    cnt_enb = 1'b1;
    repeat (n) step();
  endtask

  task automatic seq(input string tag, input logic [1:0] m, input logic [11:0] lim,
                     input int n, input logic [11:0] exp[8]);
    Xmode   = m;
    LoadVal = lim;
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s[%0d]", tag, i), out, exp[i]);
    end
  endtask

  initial begin
    #2;
    chk("reset_state", out, 12'd0);
    step();
    rst_n = 1'b1;
    run_to(12'd100, 37);
    chk("pre_reset_37", out, 12'd37);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", out, 12'd0);
    #1 rst_n = 1'b1;
    seq("up_lv3", 2'b00, 12'd3, 5, '{12'd1, 12'd2, 12'd3, 12'd0, 12'd1, 12'd0, 12'd0, 12'd0});

    pulse_reset();
    seq("down_lv50", 2'b01, 12'd50, 3, '{12'd50, 12'd49, 12'd48, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
    cnt_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold[%0d]", i), out, 12'd48);
    end
    cnt_enb = 1'b1;
    step();
    chk("down_resume", out, 12'd47);

    pulse_reset();
    seq("bounce_lv3", 2'b10, 12'd3, 8, '{12'd1, 12'd2, 12'd3, 12'd2, 12'd1, 12'd0, 12'd1, 12'd2});
    seq("bounce_lv0", 2'b10, 12'd0, 2, '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

    pulse_reset();
    seq("step2_lv5", 2'b11, 12'd5, 4, '{12'd2, 12'd4, 12'd0, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0});

    pulse_reset();
    LoadVal = 12'd4095;
    Xmode   = 2'b11;
    repeat (2047) step();
    chk("step2_to_4094", out, 12'd4094);
    seq("up_lv4095", 2'b00, 12'd4095, 2, '{12'd4095, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
    pulse_reset();
    Xmode = 2'b11;
    repeat (2047) step();
    seq("step2_4094_wrap", 2'b11, 12'd4095, 1, '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

    run_to(12'd100, 60);
    chk("at_60", out, 12'd60);
    seq("shrink_up", 2'b00, 12'd50, 1, '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
    run_to(12'd100, 60);
    seq("shrink_down", 2'b01, 12'd50, 1, '{12'd50, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
    run_to(12'd100, 60);
    seq("shrink_bounce", 2'b10, 12'd50, 2, '{12'd50, 12'd49, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

    run_to(12'd4000, 10);
    chk("at_10", out, 12'd10);
    seq("mix_up", 2'b00, 12'd4000, 1, '{12'd11, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
    seq("mix_bounce", 2'b10, 12'd4000, 1, '{12'd12, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
    seq("mix_step2", 2'b11, 12'd4000, 1, '{12'd14, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/xmode_counter.md
Name: xmode_counter

Overview:
- Configurable 12-bit modulo counter used by the pattern-generation datapath as a coordinate/sequence source.
- Mode input Xmode selects one of four stepping modes: up-wrap, down-reload, up/down bounce, double-step up.
- Runtime terminal value LoadVal bounds all modes; counting is gated by cnt_enb.

Parameters:
- WIDTH, 12, counter and LoadVal width in bits.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- cnt_enb  input  1  count enable; 0 = hold
- Xmode  input  2  mode select (00 up, 01 down, 10 bounce, 11 double-step up)
- LoadVal  input  WIDTH  terminal value, unsigned, sampled every cycle
- out  output  WIDTH  current count, registered

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. While rst_n=0: out=0, internal direction flag dir=UP. Reset takes effect immediately, regardless of clk, and overrides any operation in progress.
- All updates occur on rising clk while rst_n=1 and cnt_enb=1. When cnt_enb=0, out and dir hold.
- out is a register driven straight to the port. The value computed from inputs at edge N is visible after edge N (1-cycle latency).
- All comparisons are unsigned. Additions are computed in WIDTH+1 bits so LoadVal=4095 never overflows silently.
- Xmode=00 (up-wrap):
  - if out >= LoadVal then out <= 0
  - else out <= out+1
  - Period is LoadVal+1.
- Xmode=01 (down-reload):
  - if out == 0 or out > LoadVal then out <= LoadVal
  - else out <= out-1
- Xmode=10 (bounce):
  - LoadVal == 0: out <= 0, dir unchanged.
  - out > LoadVal: out <= LoadVal, dir <= DOWN.
  - dir=UP: if out >= LoadVal then out <= LoadVal-1 and dir <= DOWN; else out <= out+1.
  - dir=DOWN: if out == 0 then out <= 1 and dir <= UP; else out <= out-1.
  - Endpoints 0 and LoadVal each appear exactly once per sweep.
- Xmode=11 (double-step up):
  - if out+2 > LoadVal then out <= 0
  - else out <= out+2
- dir is touched only in mode 10. Other modes leave it unchanged.
- Mode or LoadVal change mid-count: no restart. The next value is computed from the current out under the new mode/LoadVal, per the rules above.
- No X propagation: unknown Xmode is not required to be handled. Synthesis uses a full case with mode 00 as default.

Decomposition:
- Shared package (e.g. counter_pkg):
  - typedef xmode_t with enumerators XM_UP=2'b00, XM_DOWN=2'b01, XM_BOUNCE=2'b10, XM_STEP2=2'b11
  - typedef dir_t (UP/DOWN)
  - localparam default WIDTH
- Single module. One combinational next-state block plus one async-reset register process.
- No sub-module is warranted.

Test Plan:
- Reset: assert rst_n=0 mid-count with out=37, no clock edge -> out=0 immediately; deassert, Xmode=00, LoadVal=3, cnt_enb=1 -> out sequence 1,2,3,0,1.
- Down/hold: Xmode=01, LoadVal=50, from out=0 -> 50,49,48; drop cnt_enb for 3 cycles -> out stays 48; re-enable -> 47.
- Bounce: Xmode=10, LoadVal=3, from reset -> 1,2,3,2,1,0,1,2; LoadVal=0 -> out=0 held.
- Double-step and width extremes: Xmode=11, LoadVal=5 -> 2,4,0,2; LoadVal=4095, out=4094, Xmode=00 -> 4095 then 0 (no overflow); Xmode=11 at out=4094 -> 0.
- Mode/limit change: counting up at out=60, switch to LoadVal=50, Xmode=00 -> next 0; with Xmode=01 -> next 50; with Xmode=10 -> next 50 with dir=DOWN, then 49.
- Mid-stream mode switch: at out=10 (LoadVal=4000), switch 00 -> 10 -> 11 on consecutive edges -> 11, 12, 14.
